// File: rtl/cdb_writeback_arbiter_if.sv
// FU-result intake and CDB broadcast bundle for the writeback arbiter.
// The slave side is the arbiter; the master side drives results and sinks the CDB.
interface cdb_writeback_arbiter_if #(
    parameter int SS         = 2,
    parameter int CDB_PORTS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int ROB_IDX_W  = 3,
    parameter int PREG_W     = 6
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [SS-1:0]                        fu_valid;
    logic [SS-1:0][ROB_IDX_W-1:0]         fu_rob_idx;
    logic [SS-1:0][PREG_W-1:0]            fu_pd;
    logic [SS-1:0]                        fu_rd_we;
    logic [SS-1:0][31:0]                  fu_value;
    logic [SS-1:0]                        fu_ready;

    logic [CDB_PORTS-1:0]                 cdb_valid;
    logic [CDB_PORTS-1:0][ROB_IDX_W-1:0]  cdb_rob_idx;
    logic [CDB_PORTS-1:0][PREG_W-1:0]     cdb_pd;
    logic [CDB_PORTS-1:0]                 cdb_rd_we;
    logic [CDB_PORTS-1:0][31:0]           cdb_value;

    logic [SS-1:0][CNT_W-1:0]             lane_count;

    modport slave (
        input  fu_valid, fu_rob_idx, fu_pd, fu_rd_we, fu_value,
        output fu_ready,
        output cdb_valid, cdb_rob_idx, cdb_pd, cdb_rd_we, cdb_value,
        output lane_count
    );

    modport master (
        output fu_valid, fu_rob_idx, fu_pd, fu_rd_we, fu_value,
        input  fu_ready,
        input  cdb_valid, cdb_rob_idx, cdb_pd, cdb_rd_we, cdb_value,
        input  lane_count
    );
endinterface

// File: rtl/cdb_writeback_arbiter.sv
// Per-lane result FIFOs feeding a round-robin arbiter onto CDB_PORTS broadcast ports.
// Absorbs FU completion bursts; CDB outputs are combinational from FIFO heads.
module cdb_writeback_arbiter #(
    parameter int SS         = 2,
    parameter int CDB_PORTS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int ROB_IDX_W  = 3,
    parameter int PREG_W     = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    cdb_writeback_arbiter_if.slave bus
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LANE_W = (SS > 1) ? $clog2(SS) : 1;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob;
        logic [PREG_W-1:0]    pd;
        logic                 we;
        logic [31:0]          val;
    } entry_t;

    entry_t            r_mem  [SS][FIFO_DEPTH];
    logic [PTR_W-1:0]  r_head [SS];
    logic [PTR_W-1:0]  r_tail [SS];
    logic [CNT_W-1:0]  r_cnt  [SS];
    logic [LANE_W-1:0] r_rr;

    logic [SS-1:0]     w_ready;
    logic [SS-1:0]     w_push;
    logic [SS-1:0]     w_grant;
    entry_t            w_head [SS];
    logic              w_any;
    logic [LANE_W-1:0] w_rr_nxt;

    // Ready looks only at registered occupancy, so a full lane stays closed
    // even in the cycle it is being drained.
    always_comb begin
        w_ready = '0;
        w_push  = '0;
        bus.fu_ready   = '0;
        bus.lane_count = '0;
        for (int l = 0; l < SS; l++) begin
            w_ready[l] = rst && !flush &&
                         (r_cnt[l] != CNT_W'(FIFO_DEPTH));
            w_push[l]  = bus.fu_valid[l] && w_ready[l];
            w_head[l]  = r_mem[l][r_head[l]];
            bus.fu_ready[l]   = w_ready[l];
            bus.lane_count[l] = r_cnt[l];
        end
    end

    always_comb begin
        int n;
        int idx;
        n        = 0;
        idx      = 0;
        w_grant  = '0;
        w_any    = 1'b0;
        w_rr_nxt = r_rr;
        bus.cdb_valid   = '0;
        bus.cdb_rob_idx = '0;
        bus.cdb_pd      = '0;
        bus.cdb_rd_we   = '0;
        bus.cdb_value   = '0;
        for (int k = 0; k < SS; k++) begin
            idx = (int'(r_rr) + k) % SS;
            for (int l = 0; l < SS; l++) begin
                if (l == idx && !flush && r_cnt[l] != '0 &&
                    n < CDB_PORTS) begin
                    w_grant[l] = 1'b1;
                    w_any      = 1'b1;
                    w_rr_nxt   = LANE_W'((l + 1) % SS);
                    for (int p = 0; p < CDB_PORTS; p++) begin
                        if (p == n) begin
                            bus.cdb_valid[p]   = 1'b1;
                            bus.cdb_rob_idx[p] = w_head[l].rob;
                            bus.cdb_pd[p]      = w_head[l].pd;
                            bus.cdb_rd_we[p]   = w_head[l].we;
                            bus.cdb_value[p]   = w_head[l].val;
                        end
                    end
                    n = n + 1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int l = 0; l < SS; l++) begin
                r_head[l] <= '0;
                r_tail[l] <= '0;
                r_cnt[l]  <= '0;
            end
            r_rr <= '0;
        end else if (flush) begin
            for (int l = 0; l < SS; l++) begin
                r_head[l] <= '0;
                r_tail[l] <= '0;
                r_cnt[l]  <= '0;
            end
            r_rr <= '0;
        end else begin
            for (int l = 0; l < SS; l++) begin
                if (w_push[l])
                    r_tail[l] <= r_tail[l] + PTR_W'(1);
                if (w_grant[l])
                    r_head[l] <= r_head[l] + PTR_W'(1);
                if (w_push[l] && !w_grant[l])
                    r_cnt[l] <= r_cnt[l] + CNT_W'(1);
                else if (!w_push[l] && w_grant[l])
                    r_cnt[l] <= r_cnt[l] - CNT_W'(1);
            end
            if (w_any)
                r_rr <= w_rr_nxt;
        end
    end

    // Storage carries no reset; stale slots are never visible past count.
    always_ff @(posedge clk) begin
        for (int l = 0; l < SS; l++) begin
            if (w_push[l]) begin
                r_mem[l][r_tail[l]] <= '{
                    rob: bus.fu_rob_idx[l],
                    pd:  bus.fu_pd[l],
                    we:  bus.fu_rd_we[l],
                    val: bus.fu_value[l]
                };
            end
        end
    end
endmodule
